// File: rtl/spi_protocol_monitor.sv
// Passive SPI frame monitor: tracks each SS_n frame, decodes the command,
// and flags MISO idle, frame length and command ordering violations.
module spi_protocol_monitor #(
  parameter int DATA_W     = 8,
  parameter int RD_LATENCY = 1,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             SS_n,
  input  logic             MOSI,
  input  logic             MISO,
  output logic [3:0]       err_pulse,
  output logic [3:0]       err_sticky,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [1:0]       last_cmd,
  output logic             busy
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CMD     = 3'd1;
  localparam logic [2:0] S_PAYLOAD = 3'd2;
  localparam logic [2:0] S_LAT     = 3'd3;
  localparam logic [2:0] S_RDATA   = 3'd4;
  localparam logic [2:0] S_END     = 3'd5;
  localparam logic [2:0] S_DRAIN   = 3'd6;

  localparam int MAXC0    = (DATA_W > RD_LATENCY) ? DATA_W : RD_LATENCY;
  localparam int MAXC     = (MAXC0 > 1) ? MAXC0 : 1;
  localparam int CW       = $clog2(MAXC + 1);
  localparam int LAT_LAST = (RD_LATENCY > 0) ? RD_LATENCY - 1 : 0;

  logic [2:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             cmd_hi_q, cmd_hi_d;
  logic [1:0]       last_cmd_q, last_cmd_d;
  logic             rd_seen_q, rd_seen_d;
  logic             wr_seen_q, wr_seen_d;
  logic             ss_prev_q, ss_prev_d;
  logic [3:0]       pulse_q, pulse_d;
  logic [3:0]       sticky_q, sticky_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             frame_inc;
  logic [1:0]       cmd_w;

  assign cmd_w = {cmd_hi_q, MOSI};

  // Frame tracking FSM, error detection and counter updates.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cmd_hi_d    = cmd_hi_q;
    last_cmd_d  = last_cmd_q;
    rd_seen_d   = rd_seen_q;
    wr_seen_d   = wr_seen_q;
    ss_prev_d   = SS_n;
    pulse_d     = '0;
    frame_inc   = 1'b0;
    pulse_d[0]  = MISO && (state_q != S_RDATA);
    unique case (state_q)
      S_IDLE: begin
        // A new frame needs a high-to-low edge; a frame already
        // underway at reset release is ignored until it ends.
        if (!SS_n && ss_prev_q) begin
          cmd_hi_d = MOSI;
          state_d  = S_CMD;
        end
      end
      S_CMD: begin
        if (SS_n) begin
          pulse_d[1] = 1'b1;
          frame_inc  = 1'b1;
          state_d    = S_IDLE;
        end else begin
          last_cmd_d = cmd_w;
          cnt_d      = '0;
          state_d    = S_PAYLOAD;
          unique case (cmd_w)
            2'b00: wr_seen_d = 1'b1;
            2'b01: pulse_d[3] = !wr_seen_q;
            2'b10: rd_seen_d = 1'b1;
            2'b11: begin
              pulse_d[3] = !rd_seen_q;
              rd_seen_d  = 1'b0;
            end
            default: ;
          endcase
        end
      end
      S_PAYLOAD: begin
        if (SS_n) begin
          pulse_d[1] = 1'b1;
          frame_inc  = 1'b1;
          state_d    = S_IDLE;
        end else if (cnt_q == CW'(DATA_W - 1)) begin
          cnt_d = '0;
          if (last_cmd_q != 2'b11)
            state_d = S_END;
          else if (RD_LATENCY == 0)
            state_d = S_RDATA;
          else
            state_d = S_LAT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_LAT: begin
        if (SS_n) begin
          pulse_d[1] = 1'b1;
          frame_inc  = 1'b1;
          state_d    = S_IDLE;
        end else if (cnt_q == CW'(LAT_LAST)) begin
          cnt_d   = '0;
          state_d = S_RDATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RDATA: begin
        if (SS_n) begin
          pulse_d[1] = 1'b1;
          frame_inc  = 1'b1;
          state_d    = S_IDLE;
        end else if (cnt_q == CW'(DATA_W - 1)) begin
          cnt_d   = '0;
          state_d = S_END;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_END: begin
        if (SS_n) begin
          frame_inc = 1'b1;
          state_d   = S_IDLE;
        end else begin
          pulse_d[2] = 1'b1;
          state_d    = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (SS_n) begin
          frame_inc = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    sticky_d    = sticky_q | pulse_q;
    frame_cnt_d = frame_cnt_q;
    if (frame_inc && (frame_cnt_q != '1))
      frame_cnt_d = frame_cnt_q + CNT_W'(1);
    err_cnt_d = err_cnt_q;
    if ((|pulse_d) && (err_cnt_q != '1))
      err_cnt_d = err_cnt_q + CNT_W'(1);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      cmd_hi_q    <= 1'b0;
      last_cmd_q  <= '0;
      rd_seen_q   <= 1'b0;
      wr_seen_q   <= 1'b0;
      ss_prev_q   <= 1'b0;
      pulse_q     <= '0;
      sticky_q    <= '0;
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cmd_hi_q    <= cmd_hi_d;
      last_cmd_q  <= last_cmd_d;
      rd_seen_q   <= rd_seen_d;
      wr_seen_q   <= wr_seen_d;
      ss_prev_q   <= ss_prev_d;
      pulse_q     <= pulse_d;
      sticky_q    <= sticky_d;
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign err_pulse  = pulse_q;
  assign err_sticky = sticky_q;
  assign frame_cnt  = frame_cnt_q;
  assign err_cnt    = err_cnt_q;
  assign last_cmd   = last_cmd_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_spi_protocol_monitor.sv
// Bench for spi_protocol_monitor: frame-level reference model
// driving directed and randomized SPI frames.
module tb_spi_protocol_monitor;
  localparam int DW = 8;
  localparam int RL = 1;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic SS_n = 1'b1;
  logic MOSI = 1'b0;
  logic MISO = 1'b0;
  logic [3:0] err_pulse, err_sticky;
  logic [CW-1:0] frame_cnt, err_cnt;
  logic [1:0] last_cmd;
  logic busy;

  spi_protocol_monitor #(
    .DATA_W(DW), .RD_LATENCY(RL), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .SS_n(SS_n),
    .MOSI(MOSI), .MISO(MISO),
    .err_pulse(err_pulse), .err_sticky(err_sticky),
    .frame_cnt(frame_cnt), .err_cnt(err_cnt),
    .last_cmd(last_cmd), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  logic          m_rd, m_wr;
  logic [3:0]    m_sticky, m_prev;
  logic [CW-1:0] m_frames, m_err;
  logic [1:0]    m_last;

  logic [8:0] q_obs[$];
  logic [8:0] q_exp[$];

  initial begin
    #500000;
    $display("FAIL watchdog: run exceeded time limit got timeout exp finish");
    $fatal(1);
  end

  task automatic model_reset();
    m_rd = 0; m_wr = 0; m_sticky = 0; m_prev = 0;
    m_frames = 0; m_err = 0; m_last = 0;
  endtask

  task automatic drive_cycle(input logic ss, input logic mosi,
                             input logic miso, input logic [3:0] ep,
                             input logic eb, input logic fend,
                             input logic ucmd, input logic [1:0] cv);
    SS_n = ss; MOSI = mosi; MISO = miso;
    @(posedge clk); #1;
    m_sticky = m_sticky | m_prev;
    m_prev = ep;
    if (ep != 4'b0 && m_err != '1) m_err = m_err + 1'b1;
    if (fend && m_frames != '1) m_frames = m_frames + 1'b1;
    if (ucmd) m_last = cv;
    q_obs.push_back({busy, err_sticky, err_pulse});
    q_exp.push_back({eb, m_sticky, ep});
  endtask

  // mode: 0 MISO quiet, 1 random only in read window, 2 plus stray ones
  task automatic run_frame(input logic [1:0] cmd, input int n,
                           input int gap, input int mode,
                           input int fk0, input int fk1);
    int L;
    logic seq, win, miso, mosi;
    logic [3:0] ep;
    L = (cmd == 2'b11) ? 2 + 2 * DW + RL : 2 + DW;
    seq = (n >= 2) && ((cmd == 2'b01 && !m_wr) || (cmd == 2'b11 && !m_rd));
    for (int k = 1; k <= n + gap; k++) begin
      win = (cmd == 2'b11) && k >= 3 + DW + RL &&
            k <= 2 + 2 * DW + RL && k <= n;
      mosi = (k == 1) ? cmd[1] : (k == 2) ? cmd[0]
           : 1'($urandom_range(0, 1));
      miso = 1'b0;
      if (mode >= 1 && win) miso = 1'($urandom_range(0, 1));
      if (mode == 2 && !win) miso = ($urandom_range(0, 15) == 0);
      if (k == fk0 || k == fk1) miso = 1'b1;
      ep[0] = miso && !win;
      ep[1] = (k == n + 1) && (n < L);
      ep[2] = (k == L + 1) && (n > L);
      ep[3] = (k == 2) && seq;
      drive_cycle(k > n, mosi, miso, ep, k <= n, k == n + 1,
                  k == 2 && n >= 2, cmd);
    end
    if (n >= 2) begin
      if (cmd == 2'b00) m_wr = 1;
      if (cmd == 2'b10) m_rd = 1;
      if (cmd == 2'b11) m_rd = 0;
    end
  endtask

  task automatic do_reset();
    rst_n = 0; SS_n = 1; MOSI = 0; MISO = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    model_reset();
    q_obs.delete();
    q_exp.delete();
    drive_cycle(1, 0, 0, 4'b0, 0, 0, 0, 2'b00);
  endtask

  task automatic test_reset();
    rst_n = 0; SS_n = 1; MOSI = 0; MISO = 1;
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if (err_pulse !== 4'b0) begin n_fail++;
      $display("FAIL reset_pulse got %b exp 0000", err_pulse); end
    n_chk++;
    if (err_sticky !== 4'b0) begin n_fail++;
      $display("FAIL reset_sticky got %b exp 0000", err_sticky); end
    n_chk++;
    if (frame_cnt !== '0) begin n_fail++;
      $display("FAIL reset_frame_cnt got %0d exp 0", frame_cnt); end
    n_chk++;
    if (err_cnt !== '0) begin n_fail++;
      $display("FAIL reset_err_cnt got %0d exp 0", err_cnt); end
    n_chk++;
    if (last_cmd !== 2'b00) begin n_fail++;
      $display("FAIL reset_last_cmd got %b exp 00", last_cmd); end
    n_chk++;
    if (busy !== 1'b0) begin n_fail++;
      $display("FAIL reset_busy got %b exp 0", busy); end
    MISO = 0;
  endtask

  task automatic test_basic();
    do_reset();
    run_frame(2'b00, 10, 1, 1, 0, 0);
    run_frame(2'b01, 10, 1, 1, 0, 0);
    run_frame(2'b10, 10, 1, 1, 0, 0);
    run_frame(2'b11, 19, 1, 1, 0, 0);
    foreach (q_exp[i]) begin
      n_chk++;
      if (q_obs[i] !== q_exp[i]) begin n_fail++;
        $display("FAIL basic cyc %0d busy/sticky/pulse got %b exp %b",
                 i, q_obs[i], q_exp[i]); end
    end
    n_chk++;
    if (err_sticky !== 4'b0) begin n_fail++;
      $display("FAIL basic_sticky got %b exp 0000", err_sticky); end
    n_chk++;
    if (frame_cnt !== 16'd4) begin n_fail++;
      $display("FAIL basic_frame_cnt got %0d exp 4", frame_cnt); end
    n_chk++;
    if (last_cmd !== 2'b11) begin n_fail++;
      $display("FAIL basic_last_cmd got %b exp 11", last_cmd); end
  endtask

  task automatic test_seq_after_reset();
    do_reset();
    run_frame(2'b11, 19, 2, 1, 0, 0);
    foreach (q_exp[i]) begin
      n_chk++;
      if (q_obs[i] !== q_exp[i]) begin n_fail++;
        $display("FAIL seq cyc %0d busy/sticky/pulse got %b exp %b",
                 i, q_obs[i], q_exp[i]); end
    end
    n_chk++;
    if (q_obs[2][3:0] !== 4'b1000) begin n_fail++;
      $display("FAIL seq_pulse got %b exp 1000", q_obs[2][3:0]); end
    n_chk++;
    if (err_cnt !== 16'd1) begin n_fail++;
      $display("FAIL seq_err_cnt got %0d exp 1", err_cnt); end
    n_chk++;
    if (frame_cnt !== 16'd1) begin n_fail++;
      $display("FAIL seq_frame_cnt got %0d exp 1", frame_cnt); end
  endtask

  task automatic test_short_long();
    do_reset();
    run_frame(2'b00, 6, 2, 0, 0, 0);
    n_chk++;
    if (frame_cnt !== 16'd1) begin n_fail++;
      $display("FAIL short_frame_cnt got %0d exp 1", frame_cnt); end
    run_frame(2'b00, 12, 2, 0, 0, 0);
    foreach (q_exp[i]) begin
      n_chk++;
      if (q_obs[i] !== q_exp[i]) begin n_fail++;
        $display("FAIL shortlong cyc %0d busy/sticky/pulse got %b exp %b",
                 i, q_obs[i], q_exp[i]); end
    end
    n_chk++;
    if (frame_cnt !== 16'd2) begin n_fail++;
      $display("FAIL long_frame_cnt got %0d exp 2", frame_cnt); end
    n_chk++;
    if (err_cnt !== 16'd2) begin n_fail++;
      $display("FAIL shortlong_err_cnt got %0d exp 2", err_cnt); end
  endtask

  task automatic test_miso_idle();
    do_reset();
    run_frame(2'b10, 10, 1, 0, 0, 0);
    run_frame(2'b11, 19, 2, 1, 11, 21);
    foreach (q_exp[i]) begin
      n_chk++;
      if (q_obs[i] !== q_exp[i]) begin n_fail++;
        $display("FAIL miso cyc %0d busy/sticky/pulse got %b exp %b",
                 i, q_obs[i], q_exp[i]); end
    end
    n_chk++;
    if (err_cnt !== 16'd2) begin n_fail++;
      $display("FAIL miso_err_cnt got %0d exp 2", err_cnt); end
    n_chk++;
    if (err_sticky !== 4'b0001) begin n_fail++;
      $display("FAIL miso_sticky got %b exp 0001", err_sticky); end
  endtask

  task automatic test_dual_error();
    do_reset();
    run_frame(2'b00, 5, 2, 0, 6, 0);
    foreach (q_exp[i]) begin
      n_chk++;
      if (q_obs[i] !== q_exp[i]) begin n_fail++;
        $display("FAIL dual cyc %0d busy/sticky/pulse got %b exp %b",
                 i, q_obs[i], q_exp[i]); end
    end
    n_chk++;
    if (q_obs[6][3:0] !== 4'b0011) begin n_fail++;
      $display("FAIL dual_pulse got %b exp 0011", q_obs[6][3:0]); end
    n_chk++;
    if (err_cnt !== 16'd1) begin n_fail++;
      $display("FAIL dual_err_cnt got %0d exp 1", err_cnt); end
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    drive_cycle(0, 0, 0, 4'b0, 1, 0, 0, 2'b00);
    drive_cycle(0, 0, 0, 4'b0, 1, 0, 1, 2'b00);
    for (int k = 0; k < 3; k++)
      drive_cycle(0, 1'($urandom_range(0, 1)), 0, 4'b0, 1, 0, 0, 2'b00);
    #1;
    rst_n = 0;
    #1;
    n_chk++;
    if ({err_pulse, err_sticky, frame_cnt, err_cnt, last_cmd, busy}
        !== '0) begin n_fail++;
      $display("FAIL midrst_outputs got %b/%0d/%0d/%b exp all zero",
               busy, frame_cnt, err_cnt, err_pulse); end
    #1;
    rst_n = 1;
    model_reset();
    for (int k = 0; k < 5; k++)
      drive_cycle(0, 1'($urandom_range(0, 1)), 0, 4'b0, 0, 0, 0, 2'b00);
    drive_cycle(1, 0, 0, 4'b0, 0, 0, 0, 2'b00);
    run_frame(2'b00, 10, 1, 0, 0, 0);
    run_frame(2'b01, 11, 2, 0, 0, 0);
    foreach (q_exp[i]) begin
      n_chk++;
      if (q_obs[i] !== q_exp[i]) begin n_fail++;
        $display("FAIL midrst cyc %0d busy/sticky/pulse got %b exp %b",
                 i, q_obs[i], q_exp[i]); end
    end
    n_chk++;
    if (frame_cnt !== 16'd2) begin n_fail++;
      $display("FAIL midrst_frame_cnt got %0d exp 2", frame_cnt); end
    n_chk++;
    if (err_cnt !== 16'd1) begin n_fail++;
      $display("FAIL midrst_err_cnt got %0d exp 1", err_cnt); end
  endtask

  task automatic test_random();
    logic [1:0] cmd;
    int L, n, kind;
    do_reset();
    for (int f = 0; f < 60; f++) begin
      cmd = 2'($urandom_range(0, 3));
      L = (cmd == 2'b11) ? 2 + 2 * DW + RL : 2 + DW;
      kind = $urandom_range(0, 3);
      if (kind == 0) n = $urandom_range(1, L - 1);
      else if (kind == 1) n = L + $urandom_range(1, 4);
      else n = L;
      run_frame(cmd, n, $urandom_range(1, 3), 2, 0, 0);
    end
    foreach (q_exp[i]) begin
      n_chk++;
      if (q_obs[i] !== q_exp[i]) begin n_fail++;
        $display("FAIL rand cyc %0d busy/sticky/pulse got %b exp %b",
                 i, q_obs[i], q_exp[i]); end
    end
    n_chk++;
    if (frame_cnt !== m_frames) begin n_fail++;
      $display("FAIL rand_frame_cnt got %0d exp %0d", frame_cnt, m_frames); end
    n_chk++;
    if (err_cnt !== m_err) begin n_fail++;
      $display("FAIL rand_err_cnt got %0d exp %0d", err_cnt, m_err); end
    n_chk++;
    if (last_cmd !== m_last) begin n_fail++;
      $display("FAIL rand_last_cmd got %b exp %b", last_cmd, m_last); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_seq_after_reset();
    test_short_long();
    test_miso_idle();
    test_dual_error();
    test_reset_mid_frame();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
